// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry type for the fetch stage.
package fetch_pkg;
    localparam int DEF_XLEN = 32;
    localparam int PC_STEP  = 4;
    localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_q_if.sv
// Fetch-to-decode handshake: queue head {pc, instr, pc+4} with valid/ready.
interface fetch_stage_q_if #(parameter int XLEN = 32);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (output out_valid, out_instr, out_pc, out_pc_plus4, input out_ready);
    modport slave  (input out_valid, out_instr, out_pc, out_pc_plus4, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO of fetch entries; QDEPTH must be a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  QDEPTH  = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(QDEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           wr_data,
    output entry_t           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    entry_t           mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap by truncation since QDEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(QDEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/fetch_stage_q.sv
// Fetch stage: PC register, +4 adder, ROM address drive, redirect flush and a fetch queue.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_stage_q
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              ADDR_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int              QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_tb,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_stage_q_if.master   dec
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic             push;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    entry_t           wr_entry;
    entry_t           head;

    // A redirect flushes the queue, so neither push nor pop takes effect that cycle.
    assign pop      = ~q_empty & dec.out_ready;
    assign push     = fetch_en & ~redirect_valid & (~q_full | pop);
    assign wr_entry = '{pc: pc, instr: imem_data};

    always_ff @(posedge clk or negedge rst_tb) begin
        if (!rst_tb)             pc <= RESET_PC;
        else if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)           pc <= pc + XLEN'(PC_STEP);
    end

    assign imem_addr = pc[ADDR_W-1:0];

    fetch_queue #(.QDEPTH(QDEPTH), .entry_t(entry_t)) u_queue (
        .clk     (clk),
        .rst_n   (rst_tb),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign dec.out_valid    = ~q_empty;
    assign dec.out_pc       = q_empty ? '0 : head.pc;
    assign dec.out_instr    = q_empty ? '0 : head.instr;
    assign dec.out_pc_plus4 = q_empty ? '0 : head.pc + XLEN'(PC_STEP);

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef FETCH_PERF_CNT_EN
    localparam logic [31:0] PERF_MAX = '1;
    logic [32:0] flushed_sum;

    // The flushed count includes an entry popped in the redirect cycle, since that pop is not credited.
    assign flushed_sum = {1'b0, perf_flushed} + 33'(q_count);

    always_ff @(posedge clk or negedge rst_tb) begin
        if (!rst_tb) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && perf_fetched != PERF_MAX) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid) perf_flushed <= flushed_sum[32] ? PERF_MAX : flushed_sum[31:0];
        end
    end
`else
    logic unused_q_count;
    assign unused_q_count = ^q_count;
`endif
endmodule

// File: tb/tb_fetch_stage_q.sv
// Self-checking bench for fetch_stage_q: spec-level queue model as scoreboard plus directed checks.
module tb_fetch_stage_q;
    import fetch_pkg::*;

    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_tb = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_data;
    logic [7:0]  imem_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_stage_q_if #(.XLEN(32)) dec();
    assign dec.out_ready = out_ready;

    fetch_stage_q #(.XLEN(32), .ADDR_W(8), .RESET_PC(32'h0), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .rst_tb         (rst_tb),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    // ROM[i] = 0x1000 + i, i = word index
    assign imem_data = 32'h1000 + {26'b0, imem_addr[7:2]};

    int n_tests = 0;
    int n_fail  = 0;

    fetch_entry_t m_q[$];
    logic [31:0]  m_pc = '0;
    logic [31:0]  m_fetched = '0;
    logic [31:0]  m_flushed = '0;

    logic [127:0] dut_out;
    assign dut_out = {dec.out_valid, dec.out_pc, dec.out_instr, dec.out_pc_plus4[30:0]};

    function automatic logic [31:0] rom(input logic [7:0] a);
        return 32'h1000 + {26'b0, a[7:2]};
    endfunction

    function automatic logic [127:0] exp_out();
        logic [31:0] p4;
        if (m_q.size() == 0) return '0;
        p4 = m_q[0].pc + 32'd4;
        return {1'b1, m_q[0].pc, m_q[0].instr, p4[30:0]};
    endfunction

    function automatic logic [127:0] pack_out(input logic v, input logic [31:0] p, input logic [31:0] i);
        logic [31:0] p4;
        p4 = p + 32'd4;
        return {v, p, i, p4[30:0]};
    endfunction

    // Advance one clock edge and update the scoreboard from the inputs applied before it.
    task automatic tick();
        logic m_pop;
        logic m_push;
        m_pop  = (m_q.size() > 0) && out_ready;
        m_push = fetch_en && !redirect_valid && ((m_q.size() < QDEPTH) || m_pop);
        @(posedge clk);
        if (redirect_valid) begin
            m_flushed = m_flushed + 32'(m_q.size());
            m_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                m_q.push_back('{pc: m_pc, instr: rom(m_pc[7:0])});
                m_pc = m_pc + 32'd4;
                m_fetched = m_fetched + 32'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_tb = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        m_q.delete();
        m_pc = '0;
        m_fetched = '0;
        m_flushed = '0;
        repeat (2) @(posedge clk);
        #3 rst_tb = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1 rst_tb = 1'b0;
        #1;
        n_tests++;
        if (dut_out !== '0 || imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: out=%h addr=%h, want all 0", dut_out, imem_addr);
        end
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        n_tests++;
        if (dec.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_before_first_edge: got %b want 0", dec.out_valid);
        end
        tick();
        n_tests++;
        if (dut_out !== pack_out(1'b1, 32'h0, 32'h1000)) begin
            n_fail++;
            $display("FAIL first_fetch: got %h want pc 0 instr 1000", dut_out);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i < 4; i++) begin
            tick();
            n_tests++;
            if (dut_out !== pack_out(1'b1, 32'(i * 4), 32'h1000 + 32'(i)) || dut_out !== exp_out()) begin
                n_fail++;
                $display("FAIL stream_%0d: got %h want pc %0d", i, dut_out, i * 4);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            fetch_en  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n_tests++;
            if (dut_out !== exp_out() || imem_addr !== m_pc[7:0]) begin
                n_fail++;
                $display("FAIL random_%0d: got out=%h addr=%h want out=%h addr=%h", i, dut_out, imem_addr, exp_out(), m_pc[7:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (imem_addr !== 8'h08 || dut_out !== pack_out(1'b1, 32'h0, 32'h1000) || m_q.size() != 2) begin
            n_fail++;
            $display("FAIL full_hold: addr=%h out=%h, want addr 08 head pc 0", imem_addr, dut_out);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            n_tests++;
            if (dut_out !== pack_out(1'b1, 32'(i * 4), 32'h1000 + 32'(i)) || dut_out !== exp_out()) begin
                n_fail++;
                $display("FAIL drain_%0d: got %h want pc %0d", i, dut_out, i * 4);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b0;
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (dec.out_valid !== 1'b0 || imem_addr !== 8'h40) begin
            n_fail++;
            $display("FAIL redirect_bubble: valid=%b addr=%h want 0/40", dec.out_valid, imem_addr);
        end
        tick();
        n_tests++;
        if (dut_out !== pack_out(1'b1, 32'h40, 32'h1010) || dut_out !== exp_out()) begin
            n_fail++;
            $display("FAIL redirect_target: got %h want pc 40 instr 1010", dut_out);
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (perf_flushed !== 32'd2 || perf_fetched !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_after_redirect: flushed=%0d fetched=%0d want 2/3", perf_flushed, perf_fetched);
        end
`endif
    endtask

    task automatic test_redirect_pop();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (dut_out !== '0 || imem_addr !== 8'h80 || m_q.size() != 0) begin
            n_fail++;
            $display("FAIL redirect_pop_empty: out=%h addr=%h want 0/80", dut_out, imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (perf_flushed !== m_flushed || perf_flushed !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_redirect_pop: flushed=%0d want 3", perf_flushed);
        end
`endif
        tick();
        n_tests++;
        if (dut_out !== pack_out(1'b1, 32'h80, 32'h1020) || dut_out !== exp_out()) begin
            n_fail++;
            $display("FAIL redirect_pop_target: got %h want pc 80", dut_out);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (imem_addr !== 8'hFC || dec.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_addr_fc: addr=%h valid=%b want fc/0", imem_addr, dec.out_valid);
        end
        tick();
        n_tests++;
        if (imem_addr !== 8'h00 || dut_out !== {1'b1, 32'hFFFF_FFFC, 32'h103F, 31'h0} || dec.out_pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_entry: addr=%h out=%h plus4=%h want 00, pc fffffffc, plus4 0", imem_addr, dut_out, dec.out_pc_plus4);
        end
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            n_tests++;
            if (dut_out !== exp_out()) begin
                n_fail++;
                $display("FAIL pre_reset_burst: got %h want %h", dut_out, exp_out());
            end
        end
        #2 rst_tb = 1'b0;
        #1;
        m_q.delete();
        m_pc = '0;
        m_fetched = '0;
        m_flushed = '0;
        n_tests++;
        if (dut_out !== '0 || imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: out=%h addr=%h want 0/00", dut_out, imem_addr);
        end
        #2 rst_tb = 1'b1;
        tick();
        n_tests++;
        if (dut_out !== pack_out(1'b1, 32'h0, 32'h1000) || dut_out !== exp_out()) begin
            n_fail++;
            $display("FAIL after_async_reset: got %h want pc 0", dut_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_random();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage_q.md
Name: fetch_stage_q

Overview:
- Parametrised successor of the single-cycle fetch path: PC register, +4 adder, instruction-memory address drive, plus redirect and back-pressure support.
- Fetched {pc, instr} pairs are buffered in a small flushable queue and presented to decode with a valid/ready handshake.
- Sits between the external combinational instruction ROM (memoria_instrucciones) and the IF/ID boundary.

Parameters:
- XLEN, 32, instruction and PC width.
- ADDR_W, 8, instruction-memory byte-address width; imem_addr = pc[ADDR_W-1:0].
- RESET_PC, 0, PC value loaded on reset.
- QDEPTH, 2, fetch-queue entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- rst_tb  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1 = fetch allowed; 0 = hold PC, no enqueue.
- imem_addr  out  ADDR_W  byte address to instruction ROM, = pc[ADDR_W-1:0].
- imem_data  in  XLEN  ROM word, combinational, same cycle as imem_addr.
- redirect_valid  in  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0).
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  XLEN  head instruction; 0 when out_valid=0.
- out_pc  out  XLEN  head PC; 0 when out_valid=0.
- out_pc_plus4  out  XLEN  out_pc+4 (mod 2^XLEN); 0 when out_valid=0.

Behaviour:
- Reset (rst_tb=0, async): pc=RESET_PC, queue count=0, rd/wr pointers=0, out_valid=0, all data outputs 0.
- push = fetch_en & !redirect_valid & (count<QDEPTH | pop).
- pop = out_valid & out_ready.
- On push: queue[wr] <= {pc, imem_data}; pc <= pc+4, wrapping mod 2^XLEN. imem_addr wraps naturally through truncation.
- On pop: the rd pointer advances.
- Push and pop in the same cycle when full are allowed: count is unchanged, with no bubble.
- Redirect has highest priority: count<=0, pointers<=0, pc<={redirect_pc[XLEN-1:2],2'b00}, no push and no pop credited that cycle.
  - out_valid is 0 in the following cycle.
  - The target instruction is enqueued at the next edge, giving exactly a 1-cycle bubble.
- Latency: after reset release, the first edge enqueues RESET_PC; out_valid=1 after that edge.
- Full and out_ready=0: pc holds, imem_addr is stable, and the queue content is held unchanged.
- fetch_en=0: pc holds and nothing is enqueued. Pops still drain the queue.
- Reset asserted mid-stream: state clears immediately, with no handshake completion.
- out_* are driven from the queue head register (registered output, no combinational path from imem_data).

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds two outputs.
  - perf_fetched out 32: counts pushes.
  - perf_flushed out 32: adds count at each redirect, i.e. the number of discarded entries.
  - Both counters saturate at 2^32-1 and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - XLEN default, PC_STEP=4, RESET_PC default.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with QDEPTH, push/pop/flush, count, and full/empty.
- PC/adder logic stays in fetch_stage_q. The ROM stays external.

Test Plan:
- Reset then out_ready=1, fetch_en=1, ROM[i]=0x1000+i:
  - Expect out_pc 0,4,8,12 on consecutive cycles, with out_instr 0x1000,0x1001,….
  - The first out_valid appears one edge after reset release.
- out_ready=0 for 5 cycles, QDEPTH=2:
  - Queue fills with pc 0,4; pc holds at 8 and imem_addr=8.
  - On out_ready=1, out_pc sequences 0,4,8 with no gap.
- Full queue, redirect_valid=1, redirect_pc=0x43:
  - Next cycle out_valid=0, pc=0x40.
  - The cycle after, out_pc=0x40.
  - perf_flushed +=2 when FETCH_PERF_CNT_EN is defined.
- Redirect and pop in the same cycle: the popped entry is not double-counted, and the queue is empty afterward.
- pc=0xFFFFFFFC, fetch:
  - Next pc=0; out_pc_plus4 of that entry is 0.
  - imem_addr is 0xFC then 0x00.
- Assert rst_tb low mid-burst, asynchronously between edges: out_valid drops immediately and pc=RESET_PC.
